// File: rtl/ram_pkg.sv
// Shared types and helpers for the parametrised synchronous RAM.
package ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    // Address width for a given depth, never narrower than one bit.
    function automatic int addr_w_for(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ram_core.sv
// Storage array with one write port and a registered read port; read data lands one edge after re.
// No backpressure: every we/re presented is performed at the next edge.
module ram_core
    import ram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = addr_w_for(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              rzero,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // The array itself carries no reset; zeroing is the sequencer's job.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rzero ? '0 : mem[raddr];
        end
    end

endmodule

// File: rtl/ram_sync_param.sv
// Single-port RAM with clear sequencer and range check; reads return after 1 cycle with a valid pulse.
// No backpressure: requests while busy (clearing) or alongside clear are silently dropped.
module ram_sync_param
    import ram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = addr_w_for(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] dados_in,
    input  logic              clear,
    output logic [DATA_W-1:0] dados_out,
    output logic              dados_valid,
    output logic              addr_err,
    output logic              busy
);

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_ptr;
    logic              clr_last;
    logic              in_range;
    logic              accept;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_re;

    assign busy     = (state == CLEAR);
    assign clr_last = (clr_ptr == LAST_C);
    assign in_range = ({1'b0, addr} < DEPTH_C);
    assign accept   = (state == IDLE) && enable && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clr_last) state_nxt = IDLE;
            IDLE:    if (clear)    state_nxt = CLEAR;
            default: state_nxt = CLEAR;
        endcase
    end

    // Pointer parks at 0 outside CLEAR so every sequence starts from word 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_ptr <= '0;
        end else if (state == CLEAR && !clr_last) begin
            clr_ptr <= clr_ptr + ADDR_W'(1);
        end else begin
            clr_ptr <= '0;
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = dados_in;
        if (state == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_ptr;
            mem_wdata = '0;
        end else if (accept && write_enable && in_range) begin
            mem_we = 1'b1;
        end
    end

    assign mem_re = accept && !write_enable;

    ram_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (mem_re),
        .raddr (addr),
        .rzero (!in_range),
        .rdata (dados_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dados_valid <= 1'b0;
            addr_err    <= 1'b0;
        end else begin
            dados_valid <= mem_re;
            addr_err    <= accept && !in_range;
        end
    end

endmodule

// File: tb/tb_ram_sync_param.sv
// Scoreboarded bench for ram_sync_param at DATA_W=8, DEPTH=6.
module tb_ram_sync_param;

    typedef struct {
        logic       vld;
        logic       err;
        logic [7:0] dat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       write_enable;
    logic [2:0] addr;
    logic [7:0] dados_in;
    logic       clear;
    logic [7:0] dados_out;
    logic       dados_valid;
    logic       addr_err;
    logic       busy;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    ram_sync_param #(
        .DATA_W (8),
        .DEPTH  (6)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .write_enable (write_enable),
        .addr         (addr),
        .dados_in     (dados_in),
        .clear        (clear),
        .dados_out    (dados_out),
        .dados_valid  (dados_valid),
        .addr_err     (addr_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: any valid or err strobe must match the oldest expected response.
    always @(negedge clk) begin
        exp_t e;
        if (dados_valid || addr_err) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got valid=%0b err=%0b data=0x%0h, required no strobe",
                         dados_valid, addr_err, dados_out);
            end else begin
                e = sb.pop_front();
                chk("strobe_valid", 32'(dados_valid), 32'(e.vld));
                chk("strobe_err", 32'(addr_err), 32'(e.err));
                chk("strobe_not_busy", 32'(busy), 32'd0);
                if (e.vld) chk("read_data", 32'(dados_out), 32'(e.dat));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        exp_t e;
        if (a >= 3'd6) begin
            e.vld = 1'b0; e.err = 1'b1; e.dat = 8'h00;
            sb.push_back(e);
        end
        enable = 1'b1; write_enable = 1'b1; addr = a; dados_in = d;
        tick();
        enable = 1'b0; write_enable = 1'b0;
    endtask

    task automatic do_read(input logic [2:0] a, input logic [7:0] exp);
        exp_t e;
        e.vld = 1'b1; e.err = (a >= 3'd6); e.dat = exp;
        sb.push_back(e);
        enable = 1'b1; write_enable = 1'b0; addr = a;
        tick();
        enable = 1'b0;
    endtask

    // Counts edges until busy drops; optionally pulses clear mid-sequence.
    task automatic wait_idle(input string name, input bit poke);
        int n;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            clear = (poke && n == 2);
            if (!busy) break;
        end
        clear = 1'b0;
        enable = 1'b0;
        write_enable = 1'b0;
        chk(name, 32'(n), 32'd6);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; write_enable = 1'b0;
        addr = '0; dados_in = '0; clear = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_dout", 32'(dados_out), 32'd0);
        chk("rst_valid", 32'(dados_valid), 32'd0);
        chk("rst_err", 32'(addr_err), 32'd0);
        rst_n = 1'b1;

        // 1: post-reset clear length and zeroed contents
        wait_idle("busy_edges_after_reset", 1'b0);
        for (int i = 0; i < 6; i++) do_read(3'(i), 8'h00);

        // 2: writes then back-to-back reads
        do_write(3'd2, 8'hA5);
        do_write(3'd5, 8'h3C);
        do_read(3'd2, 8'hA5);
        do_read(3'd5, 8'h3C);

        // 3: out-of-range write and read
        do_write(3'd0, 8'h11);
        do_write(3'd6, 8'h77);
        do_read(3'd7, 8'h00);
        do_read(3'd0, 8'h11);
        do_read(3'd6, 8'h00);

        // 4: clear beats a simultaneous read; requests during busy are ignored
        do_write(3'd1, 8'hFF);
        do_read(3'd1, 8'hFF);
        clear = 1'b1; enable = 1'b1; write_enable = 1'b0; addr = 3'd1;
        tick();
        clear = 1'b0;
        chk("busy_after_clear", 32'(busy), 32'd1);
        chk("dout_kept_by_clear", 32'(dados_out), 32'hFF);
        enable = 1'b1; write_enable = 1'b1; addr = 3'd2; dados_in = 8'h99;
        wait_idle("busy_edges_after_clear", 1'b1);
        do_read(3'd1, 8'h00);
        do_read(3'd2, 8'h00);
        do_read(3'd5, 8'h00);

        // 5: reset in the third cycle of a clear restarts the sequence
        do_write(3'd3, 8'h42);
        do_read(3'd3, 8'h42);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        tick();
        chk("dout_before_rst", 32'(dados_out), 32'h42);
        rst_n = 1'b0;
        #1;
        chk("midclr_rst_busy", 32'(busy), 32'd1);
        chk("midclr_rst_dout", 32'(dados_out), 32'd0);
        chk("midclr_rst_valid", 32'(dados_valid), 32'd0);
        chk("midclr_rst_err", 32'(addr_err), 32'd0);
        tick();
        rst_n = 1'b1;
        wait_idle("busy_edges_after_midclr_rst", 1'b0);
        for (int i = 0; i < 6; i++) do_read(3'(i), 8'h00);

        // 6: write then immediate read of the same word
        do_write(3'd4, 8'h5A);
        do_read(3'd4, 8'h5A);

        tick();
        tick();
        tick();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_sync_param.md
# ram_sync_param

Parametrised synchronous single-port RAM, the next generation of the team's 2x8 RAM. Width and depth are configurable, and reads are registered with a one-cycle latency and a valid strobe. A built-in clear sequencer zeroes the array after reset and on request. Addresses at or beyond DEPTH are rejected and flagged. The block is the standard storage primitive behind register files and small buffers in the datapath exercises.

## Interface
Parameters:
- DATA_W, 8, word width in bits (≥1)
- DEPTH, 16, number of words (≥2, need not be a power of two)
- ADDR_W, $clog2(DEPTH), address width; derived, never overridden

Ports:
- clk  in  1  rising-edge clock, sole clock domain
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  operation request, sampled each rising edge
- write_enable  in  1  1 = write, 0 = read; meaningful only with enable
- addr  in  ADDR_W  word address
- dados_in  in  DATA_W  write data
- clear  in  1  one-cycle request to zero the whole array
- dados_out  out  DATA_W  registered read data
- dados_valid  out  1  one-cycle pulse: dados_out carries a new read result
- addr_err  out  1  one-cycle pulse: the accepted operation had addr ≥ DEPTH
- busy  out  1  clear sequence in progress; requests are ignored

## Operation
- Reset values: dados_out=0, dados_valid=0, addr_err=0, busy=1. State=CLEAR, clear pointer=0.
- The memory array has no reset; contents are zeroed only by the clear sequencer.
- FSM states:
  - CLEAR: on each edge write 0 to word ptr, then ptr++. When ptr=DEPTH-1 is written, go to IDLE. busy=1 throughout.
  - IDLE: busy=0; accept operations.
- In IDLE, clear=1 moves to CLEAR with ptr=0. clear wins over a simultaneous enable; that operation is dropped without valid or err.
- clear while in CLEAR is ignored; the sequence does not restart.
- An operation is accepted when enable=1, busy=0 and clear=0. Otherwise it has no effect.
- Accepted write, addr<DEPTH: mem[addr]←dados_in at the edge. No dados_valid pulse.
- Accepted read, addr<DEPTH: dados_out←mem[addr] at the edge. dados_valid=1 for that cycle.
- Accepted op with addr≥DEPTH:
  - Write is dropped.
  - Read sets dados_out=0 and pulses dados_valid.
  - Both pulse addr_err.
- dados_out holds its last value when no read completes. Clear does not alter it.
- A write followed by a read of the same address on the next cycle returns the new data.

## Timing
- Read latency: 1 cycle. With addr/enable presented before edge N, dados_out and dados_valid are valid after edge N until edge N+1.
- Back-to-back reads on consecutive cycles give consecutive one-cycle valid pulses.
- Clear duration: exactly DEPTH edges. busy falls after the DEPTH-th edge following reset release or following the clear acceptance edge.
- The first operation is accepted on the next edge after busy falls.
- Reset mid-clear or mid-read: all outputs return to reset values immediately (asynchronous). The clear restarts from word 0 after release.
- Outputs dados_valid and addr_err are never asserted while busy=1.

## Structure
- Package ram_pkg:
  - state enum {CLEAR, IDLE}
  - function returning ADDR_W for a given DEPTH (minimum 1)
- Sub-module ram_core holds the storage array:
  - single write port (we, waddr, wdata)
  - registered read port
  - the top muxes the clear sequencer and user writes into the write port
- Top level holds the FSM, clear pointer, range check and output strobes.

## Test plan
All scenarios use DATA_W=8, DEPTH=6, ADDR_W=3.
1. Reset release → busy=1 for exactly 6 edges, then 0. Read of addr 0..5 → dados_out=0x00 each, dados_valid pulses six times.
2. Write 0xA5@2, 0x3C@5, then read 2 and 5 back-to-back → 0xA5 then 0x3C on consecutive cycles, each with a valid pulse.
3. Write 0x77@6, then read addr 7:
   - write: addr_err pulse, no valid
   - read: dados_out=0x00, dados_valid=1, addr_err=1
   - read of addr 0: returns the prior value, proving the write was dropped
4. Write 0xFF@1, then clear with a simultaneous read of 1:
   - no valid pulse that cycle
   - busy=1 for 6 cycles; requests during busy are ignored
   - read 1 afterwards returns 0x00
5. Assert rst_n=0 in the third cycle of a clear → outputs at reset values at once. After release a full 6-cycle clear runs, and all words read 0.
6. Write 0x5A@4 on edge N, read 4 on edge N+1 → dados_out=0x5A after N+1.
